// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/valid side plus the
// valid/ready hand-off to the control unit and status outputs.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_valid;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              instr_ready;
    logic              pc_jump;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    modport master (
        output imem_addr, imem_req, instruction, instr_valid, pc, halted,
        input  imem_rdata, imem_valid, instr_ready, pc_jump
    );

    modport slave (
        input  imem_addr, imem_req, instruction, instr_valid, pc, halted,
        output imem_rdata, imem_valid, instr_ready, pc_jump
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time and holds
// it until the control unit accepts it; a HALT_OP word stops fetch until reset.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'b1111
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              imem_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        imem_req = 1'b0;
        case (state_q)
            // One dead cycle lets any response to a reset-aborted request drain.
            IDLE: state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_valid) begin
                    instr_d = bus.imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    pc_d    = bus.pc_jump ? instr_q[ADDR_W-1:0] : pc_q + 1'b1;
                    valid_d = 1'b0;
                    if (instr_q[DATA_W-1 -: 4] == HALT_OP) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a program-level model walks the
// memory image and queues the expected (pc, word) stream for a negedge monitor.
module tb_instr_fetch_unit;

    localparam logic [7:0] RESET_PC = 8'hFF;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] word;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    instr_fetch_unit #(
        .ADDR_W(8), .DATA_W(16), .RESET_PC(RESET_PC), .HALT_OP(4'b1111)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    exp_t        q[$];
    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned accepts    = 0;
    bit          check_en   = 1'b0;
    bit          exp_halted = 1'b0;
    bit          exp_reset  = 1'b0;
    bit          exp_req    = 1'b0;
    logic [7:0]  model_pc   = RESET_PC;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got no progress, expected activity at %0t", name, $time);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (check_en) begin
            check("halted", 32'(bus.halted), 32'(exp_halted));
            if (exp_reset) begin
                check("reset_instruction", 32'(bus.instruction), 32'h0);
                check("reset_instr_valid", 32'(bus.instr_valid), 32'h0);
                check("reset_imem_req", 32'(bus.imem_req), 32'h0);
                check("reset_pc", 32'(bus.pc), 32'(RESET_PC));
            end
            if (exp_req)
                check("first_req", 32'(bus.imem_req), 32'h1);
            if (exp_halted) begin
                check("halt_imem_req", 32'(bus.imem_req), 32'h0);
                check("halt_instr_valid", 32'(bus.instr_valid), 32'h0);
                check("halt_pc", 32'(bus.pc), 32'(model_pc));
            end else if (q.size() > 0) begin
                check("pc", 32'(bus.pc), 32'(q[0].pc));
                if (bus.imem_req)
                    check("imem_addr", 32'(bus.imem_addr), 32'(q[0].pc));
                if (bus.instr_valid)
                    check("instruction", 32'(bus.instruction), 32'(q[0].word));
                if (bus.instr_valid && bus.instr_ready && !rst) begin
                    void'(q.pop_front());
                    accepts++;
                end
            end else begin
                fail("queue_empty");
            end
        end
    end

    // Stimulus, memory responder and reference model
    initial begin
        int unsigned rst_cycles;
        int unsigned wait_left;
        int unsigned halt_cnt;
        int unsigned idle_cnt;
        bit          prev_rst;
        bit          prev2_rst;
        bit          acc_pend;
        bit          jump_pend;
        logic [15:0] word;
        logic [7:0]  nxt;

        bus.imem_rdata  = '0;
        bus.imem_valid  = 1'b0;
        bus.instr_ready = 1'b0;
        bus.pc_jump     = 1'b0;
        prev_rst  = 1'b1;
        prev2_rst = 1'b1;
        acc_pend  = 1'b0;
        jump_pend = 1'b0;
        wait_left = 0;
        halt_cnt  = 0;
        idle_cnt  = 0;

        for (int ep = 0; ep < 10; ep++) begin
            for (int i = 0; i < 256; i++)
                mem[i] = 16'($urandom);
            rst_cycles = 1 + $urandom_range(0, 1);
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(posedge clk);
                #2;
                // Consequences of the edge that just passed
                exp_req = prev2_rst && !prev_rst;
                if (prev_rst) begin
                    q.delete();
                    model_pc = RESET_PC;
                    q.push_back('{pc: RESET_PC, word: mem[RESET_PC]});
                    exp_halted = 1'b0;
                    exp_reset  = 1'b1;
                    check_en   = 1'b1;
                    halt_cnt   = 0;
                    idle_cnt   = 0;
                end else begin
                    exp_reset = 1'b0;
                    if (acc_pend) begin
                        word     = mem[model_pc];
                        nxt      = jump_pend ? word[7:0] : model_pc + 8'd1;
                        model_pc = nxt;
                        idle_cnt = 0;
                        if (word[15:12] == 4'hF)
                            exp_halted = 1'b1;
                        else
                            q.push_back('{pc: nxt, word: mem[nxt]});
                    end else if (!exp_halted) begin
                        idle_cnt++;
                        if (idle_cnt > 60) begin
                            fail("fetch_progress");
                            idle_cnt = 0;
                        end
                    end
                end

                // Reset decisions: leave HALT after a while, plus rare mid-run pulses
                if (rst_cycles == 0 && exp_halted) begin
                    halt_cnt++;
                    if (halt_cnt > 6) rst_cycles = 1;
                end
                if (rst_cycles == 0 && !exp_halted && $urandom_range(0, 99) == 0)
                    rst_cycles = 1 + $urandom_range(0, 1);
                rst = (rst_cycles > 0);
                if (rst_cycles > 0) rst_cycles--;

                bus.instr_ready = ($urandom_range(0, 2) != 0);
                bus.pc_jump     = ($urandom_range(0, 3) == 0);
                acc_pend  = bus.instr_ready && bus.instr_valid && !rst;
                jump_pend = bus.pc_jump;

                // Memory with 0..3 wait states; stray valid pulses when not requested
                if (bus.imem_req) begin
                    if (wait_left == 0) begin
                        bus.imem_valid = 1'b1;
                        bus.imem_rdata = mem[bus.imem_addr];
                        wait_left      = $urandom_range(0, 3);
                    end else begin
                        bus.imem_valid = 1'b0;
                        bus.imem_rdata = 16'($urandom);
                        wait_left--;
                    end
                end else begin
                    bus.imem_valid = 1'($urandom_range(0, 1));
                    bus.imem_rdata = 16'($urandom);
                end

                prev2_rst = prev_rst;
                prev_rst  = rst;
            end
        end

        @(posedge clk);
        #2;
        check("accept_activity", 32'(accepts > 100), 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
